// File: rtl/position_integrator.sv
// position_integrator: per-frame fixed-point position update with floor/platform collision and KO detection.
// Optional build macro PLATFORM_EN adds a one-way platform at Y=300 spanning X=260..380.
`default_nettype none

module position_integrator #(
   parameter int SPAWN_X = 320,
   parameter int SPAWN_Y = 100,
   parameter int FLOOR_Y = 400,
   parameter int STAGE_L = 100,
   parameter int STAGE_R = 540
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic        spawn,
   input  logic [10:0] vel_x_in,
   input  logic [10:0] vel_y_in,
   output logic [11:0] pos_x,
   output logic [11:0] pos_y,
   output logic        is_grounded,
   output logic        landed_pulse,
   output logic        out_of_bounds,
   output logic        update_done
);

   localparam logic signed [11:0] c_spawn_x = 12'(SPAWN_X);
   localparam logic signed [11:0] c_spawn_y = 12'(SPAWN_Y);
   localparam logic signed [11:0] c_floor_y = 12'(FLOOR_Y);
   localparam logic signed [11:0] c_stage_l = 12'(STAGE_L);
   localparam logic signed [11:0] c_stage_r = 12'(STAGE_R);
   localparam logic signed [11:0] c_x_max   = 12'sd639;
   localparam logic signed [11:0] c_y_max   = 12'sd479;
   localparam logic signed [11:0] c_y_min   = -12'sd128;
`ifdef PLATFORM_EN
   localparam logic signed [11:0] c_plat_y  = 12'sd300;
   localparam logic signed [11:0] c_plat_l  = 12'sd260;
   localparam logic signed [11:0] c_plat_r  = 12'sd380;
`endif

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ADD     = 2'd1,
      COLLIDE = 2'd2,
      COMMIT  = 2'd3
   } state_t;

   state_t             r_state;
   logic signed [13:0] r_px;
   logic signed [13:0] r_py;
   logic signed [11:0] r_old_y;
   logic        [10:0] r_vx;
   logic        [10:0] r_vy;
   logic               r_gnd_nx;
   logic               r_ko_nx;

   logic signed [11:0] w_nx;
   logic signed [11:0] w_ny;
   logic signed [11:0] w_snap_y;
   logic signed [11:0] w_y_post;
   logic               w_falling;
   logic               w_in_stage;
   logic               w_land_stage;
   logic               w_land;
   logic               w_off_edge;
   logic               w_gnd_nx;
   logic               w_ko;

   assign w_nx         = r_px[13:2];
   assign w_ny         = r_py[13:2];
   assign w_falling    = ~r_vy[10];
   assign w_in_stage   = (w_nx >= c_stage_l) && (w_nx <= c_stage_r);
   assign w_land_stage = w_falling && (r_old_y <= c_floor_y) && (w_ny >= c_floor_y) && w_in_stage;

`ifdef PLATFORM_EN
   logic r_on_plat;
   logic r_on_plat_nx;
   logic w_in_plat;
   logic w_land_plat;

   assign w_in_plat   = (w_nx >= c_plat_l) && (w_nx <= c_plat_r);
   assign w_land_plat = w_falling && (r_old_y <= c_plat_y) && (w_ny >= c_plat_y) && w_in_plat;
   assign w_land      = w_land_plat | w_land_stage;
   assign w_snap_y    = w_land_plat ? c_plat_y : c_floor_y;
   // Walk-off is judged against whichever surface the character is standing on.
   assign w_off_edge  = r_on_plat ? ~w_in_plat : ~w_in_stage;
`else
   assign w_land      = w_land_stage;
   assign w_snap_y    = c_floor_y;
   assign w_off_edge  = ~w_in_stage;
`endif

   assign w_gnd_nx = w_land ? 1'b1 : ((r_vy[10] | w_off_edge) ? 1'b0 : is_grounded);
   // KO is judged on the post-snap height so a fast landing is not a KO.
   assign w_y_post = w_land ? w_snap_y : w_ny;
   assign w_ko     = (w_nx < 12'sd0) || (w_nx > c_x_max) || (w_y_post > c_y_max) || (w_y_post < c_y_min);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_px          <= {c_spawn_x, 2'b00};
         r_py          <= {c_spawn_y, 2'b00};
         r_old_y       <= c_spawn_y;
         r_vx          <= '0;
         r_vy          <= '0;
         r_gnd_nx      <= 1'b0;
         r_ko_nx       <= 1'b0;
         pos_x         <= c_spawn_x;
         pos_y         <= c_spawn_y;
         is_grounded   <= 1'b0;
         landed_pulse  <= 1'b0;
         out_of_bounds <= 1'b0;
         update_done   <= 1'b0;
`ifdef PLATFORM_EN
         r_on_plat     <= 1'b0;
         r_on_plat_nx  <= 1'b0;
`endif
      end else if (spawn) begin
         r_state       <= IDLE;
         r_px          <= {c_spawn_x, 2'b00};
         r_py          <= {c_spawn_y, 2'b00};
         r_gnd_nx      <= 1'b0;
         r_ko_nx       <= 1'b0;
         pos_x         <= c_spawn_x;
         pos_y         <= c_spawn_y;
         is_grounded   <= 1'b0;
         landed_pulse  <= 1'b0;
         out_of_bounds <= 1'b0;
         update_done   <= 1'b0;
`ifdef PLATFORM_EN
         r_on_plat     <= 1'b0;
         r_on_plat_nx  <= 1'b0;
`endif
      end else begin
         landed_pulse <= 1'b0;
         update_done  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (frame_tick && !out_of_bounds) begin
                  r_vx    <= vel_x_in;
                  r_vy    <= vel_y_in;
                  r_state <= ADD;
               end
            end
            ADD: begin
               r_old_y <= r_py[13:2];
               r_px    <= r_px + {{3{r_vx[10]}}, r_vx};
               r_py    <= r_py + {{3{r_vy[10]}}, r_vy};
               r_state <= COLLIDE;
            end
            COLLIDE: begin
               if (w_land) begin
                  r_py <= {w_snap_y, 2'b00};
               end
               r_gnd_nx <= w_gnd_nx;
               r_ko_nx  <= w_ko;
`ifdef PLATFORM_EN
               r_on_plat_nx <= w_land ? w_land_plat : r_on_plat;
`endif
               r_state  <= COMMIT;
            end
            COMMIT: begin
               pos_x         <= r_px[13:2];
               pos_y         <= r_py[13:2];
               is_grounded   <= r_gnd_nx;
               landed_pulse  <= r_gnd_nx & ~is_grounded;
               out_of_bounds <= out_of_bounds | r_ko_nx;
               update_done   <= 1'b1;
`ifdef PLATFORM_EN
               r_on_plat     <= r_on_plat_nx;
`endif
               r_state       <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/position_integrator.md
POSITION_INTEGRATOR -- requirements
Module: position_integrator

Interface
REQ-001 Parameter SPAWN_X, default 320: respawn/reset X position, integer pixels.
REQ-002 Parameter SPAWN_Y, default 100: respawn/reset Y position, integer pixels.
REQ-003 Parameter FLOOR_Y, default 400: main-stage top surface Y.
REQ-004 Parameter STAGE_L, default 100: inclusive left edge of the main stage.
REQ-005 Parameter STAGE_R, default 540: inclusive right edge of the main stage.
REQ-006 clk  in  1  single system clock; all logic on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 frame_tick  in  1  one-cycle pulse that starts one position update.
REQ-009 spawn  in  1  respawn request at the top of the priority order.
REQ-010 vel_x_in  in  11  signed X velocity, quarter-pixels/frame, positive = right.
REQ-011 vel_y_in  in  11  signed Y velocity, quarter-pixels/frame, positive = down.
REQ-012 pos_x  out  12  signed integer X position.
REQ-013 pos_y  out  12  signed integer Y position.
REQ-014 is_grounded  out  1  character is standing on a surface; fed back to the velocity engine.
REQ-015 landed_pulse  out  1  one-cycle pulse on an airborne-to-grounded transition.
REQ-016 out_of_bounds  out  1  sticky KO flag.
REQ-017 update_done  out  1  one-cycle pulse when new outputs are committed.

Function
REQ-018 Internal position SHALL be 14-bit signed fixed point: 12 integer bits, 2 fraction bits; pos_x/pos_y SHALL be the integer part.
REQ-019 FSM SHALL have states IDLE, ADD, COLLIDE, COMMIT, advancing one state per cycle; from COMMIT it returns to IDLE.
REQ-020 In IDLE, frame_tick SHALL latch vel_x_in/vel_y_in; frame_tick in any other state, or while out_of_bounds=1, SHALL be ignored.
REQ-021 ADD SHALL sign-extend each velocity to 14 bits and add it to the position; no saturation is applied.
REQ-022 COLLIDE, landing: if latched vel_y >= 0, old y <= FLOOR_Y, new y >= FLOOR_Y, and STAGE_L <= new x <= STAGE_R, then y SHALL snap to FLOOR_Y with fraction 0 and grounded SHALL set.
REQ-023 COLLIDE, leaving ground: grounded SHALL clear if latched vel_y < 0, or if new x is outside [STAGE_L, STAGE_R] with no landing.
REQ-024 COLLIDE, KO: KO SHALL flag if new integer x < 0, x > 639, y > 479, or y < -128.
REQ-025 COMMIT SHALL update all outputs in one cycle, so update_done follows frame_tick by 3 cycles.
REQ-026 In COMMIT, landed_pulse SHALL assert together with update_done when is_grounded goes 0 to 1.
REQ-027 out_of_bounds SHALL remain set until spawn or reset.
REQ-028 spawn, in any state, SHALL on the next edge load SPAWN_X/SPAWN_Y with fraction 0 and clear is_grounded and out_of_bounds.
REQ-029 spawn SHALL abort any in-flight update with no update_done, and return the FSM to IDLE.
REQ-030 spawn and frame_tick in the same cycle: spawn SHALL win and the tick SHALL be dropped.

Reset
REQ-031 Reset low SHALL immediately force: state IDLE; pos_x=SPAWN_X; pos_y=SPAWN_Y; fractions 0; is_grounded, landed_pulse, out_of_bounds, update_done all 0.
REQ-032 Reset asserted mid-update SHALL discard that update; no update_done SHALL follow.

Configuration
REQ-033 Macro PLATFORM_EN defined SHALL add one one-way platform: PLAT_Y=300, x range 260..380 inclusive.
REQ-034 The platform SHALL use the REQ-022 landing rule: rising through it passes, falling onto it lands.
REQ-035 The platform SHALL use the REQ-023 walk-off rule against its own edges.
REQ-036 If both surfaces qualify in one update, the platform SHALL take priority.
REQ-037 Without PLATFORM_EN, only the main stage SHALL exist, with no platform logic.

Verification
REQ-038 Reset release, then frame_tick with vel_x=8, vel_y=0 -> 3 cycles later pos_x=322, pos_y=100, update_done=1 for one cycle.
REQ-039 Airborne at y=396, x=320; tick with vel_y=32 -> pos_y=400, is_grounded=1, landed_pulse=1 for one cycle.
REQ-040 Grounded at x=539; tick with vel_x=8 -> pos_x=541, is_grounded=0.
REQ-041 Four ticks with vel_x=1 from x=320 -> pos_x reads 320,320,320,321.
REQ-042 At x=636; tick with vel_x=20 -> pos_x=641, out_of_bounds=1; further ticks give no update_done; spawn -> pos=(320,100), out_of_bounds=0.
REQ-043 PLATFORM_EN: at y=310, x=300; vel_y=-16 -> y=306, not grounded; from y=298, vel_y=16 -> y=300, grounded; spawn together with tick -> spawn position, no update_done.
